// File: rtl/mul8_err_monitor_if.sv
// Sample stream from an 8x8 approximate multiplier: operands, approximate product, valid/ready.
interface mul8_err_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] p_apx;

  modport master (output in_valid, a, b, p_apx, input in_ready);
  modport slave  (input in_valid, a, b, p_apx, output in_ready);
endinterface

// File: rtl/mul8_err_monitor.sv
// Error-characterisation stage for an approximate 8x8 multiplier: MAE/WCE/EP statistics over a run.
// Optional MUL8_ERR_MONITOR_SQ_EN adds a saturating sum of squared errors (sum_sq_err).
module mul8_err_monitor #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  mul8_err_monitor_if.slave    s_if,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [ACC_W-1:0]     sum_abs_err,
  output logic [15:0]          max_err,
  output logic [7:0]           max_a,
  output logic [7:0]           max_b
`ifdef MUL8_ERR_MONITOR_SQ_EN
  ,
  output logic [47:0]          sum_sq_err
`endif
);

  // state   | meaning
  // S_IDLE  | after reset, waiting for start
  // S_RUN   | accepting samples until n_samples transfers
  // S_DRAIN | two cycles letting S2/S3 flush the last samples
  // S_DONE  | results frozen, done high, start re-arms
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam int SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'({ACC_W{1'b1}});

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
  logic               drain_q, drain_d;
  logic [CNT_W-1:0]   n_q, n_d, cnt_q, cnt_d, errc_q, errc_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [15:0]        max_q, max_d;
  logic [7:0]         maxa_q, maxa_d, maxb_q, maxb_d;
  logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s2_mis_q, s2_mis_d;
  logic [7:0]         s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic [15:0]        s1_p_q, s1_p_d, s2_err_q, s2_err_d;

  logic               xfer;
  logic [15:0]        exact, err_abs;
  logic [16:0]        diff;
  logic [SUM_W-1:0]   sum_ext, sum_sat;

`ifdef MUL8_ERR_MONITOR_SQ_EN
  logic [31:0]        s2_sq_q, s2_sq_d;
  logic [47:0]        sq_sum_q, sq_sum_d;
  logic [48:0]        sq_ext;
`endif

  assign xfer    = s_if.in_valid && in_ready_q;
  assign exact   = {8'h00, s1_a_q} * {8'h00, s1_b_q};
  assign diff    = {1'b0, exact} - {1'b0, s1_p_q};
  // Negative difference means the multiplier overestimated; take the two's-complement magnitude.
  assign err_abs = diff[16] ? (~diff[15:0] + 16'd1) : diff[15:0];
  assign sum_ext = SUM_W'(sum_q) + SUM_W'(s2_err_q);
  assign sum_sat = (sum_ext > SUM_MAX) ? SUM_MAX : sum_ext;
`ifdef MUL8_ERR_MONITOR_SQ_EN
  assign sq_ext  = {1'b0, sq_sum_q} + {17'h0, s2_sq_q};
`endif

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = done_q;
    drain_d    = drain_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    errc_d     = errc_q;
    sum_d      = sum_q;
    max_d      = max_q;
    maxa_d     = maxa_q;
    maxb_d     = maxb_q;
    s1_vld_d   = xfer;
    s1_a_d     = xfer ? s_if.a : s1_a_q;
    s1_b_d     = xfer ? s_if.b : s1_b_q;
    s1_p_d     = xfer ? s_if.p_apx : s1_p_q;
    s2_vld_d   = s1_vld_q;
    s2_a_d     = s1_a_q;
    s2_b_d     = s1_b_q;
    s2_err_d   = err_abs;
    s2_mis_d   = (err_abs != 16'd0);
`ifdef MUL8_ERR_MONITOR_SQ_EN
    s2_sq_d    = {16'h0, err_abs} * {16'h0, err_abs};
    sq_sum_d   = sq_sum_q;
`endif

    if (s2_vld_q) begin
      if (s2_mis_q) errc_d = errc_q + CNT_W'(1);
      sum_d = sum_sat[ACC_W-1:0];
      if (s2_err_q > max_q) begin
        max_d  = s2_err_q;
        maxa_d = s2_a_q;
        maxb_d = s2_b_q;
      end
`ifdef MUL8_ERR_MONITOR_SQ_EN
      sq_sum_d = sq_ext[48] ? {48{1'b1}} : sq_ext[47:0];
`endif
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d    = n_samples;
          cnt_d  = '0;
          errc_d = '0;
          sum_d  = '0;
          max_d  = '0;
          maxa_d = '0;
          maxb_d = '0;
`ifdef MUL8_ERR_MONITOR_SQ_EN
          sq_sum_d = '0;
`endif
          if (n_samples == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_RUN;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
            done_d     = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == n_q) begin
            state_d    = S_DRAIN;
            in_ready_d = 1'b0;
            drain_d    = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drain_q    <= 1'b0;
      n_q        <= '0;
      cnt_q      <= '0;
      errc_q     <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      maxa_q     <= '0;
      maxb_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_p_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_err_q   <= '0;
      s2_mis_q   <= 1'b0;
`ifdef MUL8_ERR_MONITOR_SQ_EN
      s2_sq_q    <= '0;
      sq_sum_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drain_q    <= drain_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      errc_q     <= errc_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      maxa_q     <= maxa_d;
      maxb_q     <= maxb_d;
      s1_vld_q   <= s1_vld_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_p_q     <= s1_p_d;
      s2_vld_q   <= s2_vld_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
      s2_err_q   <= s2_err_d;
      s2_mis_q   <= s2_mis_d;
`ifdef MUL8_ERR_MONITOR_SQ_EN
      s2_sq_q    <= s2_sq_d;
      sq_sum_q   <= sq_sum_d;
`endif
    end
  end

  assign s_if.in_ready = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sample_count  = cnt_q;
  assign err_count     = errc_q;
  assign sum_abs_err   = sum_q;
  assign max_err       = max_q;
  assign max_a         = maxa_q;
  assign max_b         = maxb_q;
`ifdef MUL8_ERR_MONITOR_SQ_EN
  assign sum_sq_err    = sq_sum_q;
`endif

endmodule
